// File: rtl/bus_arbiter_if.sv
// Shared-memory arbitration bundle: per-master requests/strobes in,
// active-low grants, owner/busy status and the steered shared bus out.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS    = 4,
  parameter int BUS_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32
);
  logic [NUM_MASTERS-1:0]                breq_;
  logic [NUM_MASTERS-1:0]                m_memread;
  logic [NUM_MASTERS-1:0]                m_memwrite;
  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0] m_adr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata;
  logic [NUM_MASTERS-1:0]                gnt_;
  logic [1:0]                            owner;
  logic                                  busy;
  logic                                  memread;
  logic                                  memwrite;
  logic [BUS_ADDR_WIDTH-1:0]             adr;
  logic [DATA_WIDTH-1:0]                 writedata;

  modport master (
    output breq_, m_memread, m_memwrite,
    output m_adr, m_wdata,
    input  gnt_, owner, busy,
    input  memread, memwrite, adr, writedata
  );

  modport slave (
    input  breq_, m_memread, m_memwrite,
    input  m_adr, m_wdata,
    output gnt_, owner, busy,
    output memread, memwrite, adr, writedata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter + bus mux for up to 4 masters with a hold limit.
// Ports: clk, reset (sync, high), bus (bus_arbiter_if.slave);
// with BUS_ARB_STAT_EN defined also stat_clr in, stall_cnt[15:0] out.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MAX_HOLD       = 8,
  parameter int BUS_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32
) (
  input  logic        clk,
  input  logic        reset,
`ifdef BUS_ARB_STAT_EN
  input  logic        stat_clr,
  output logic [15:0] stall_cnt,
`endif
  bus_arbiter_if.slave bus
);

  localparam int NM = NUM_MASTERS;
  localparam logic [NM-1:0] ONE = NM'(1);
  localparam logic [7:0] HMAX = 8'(MAX_HOLD);
  localparam logic [7:0] HLAST = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [NM-1:0] gnt_r, gnt_nx;
  logic [1:0]    owner_r, owner_nx;
  logic          busy_r, busy_nx;
  logic [1:0]    ptr_r, ptr_nx;
  logic [7:0]    hcnt_r, hcnt_nx;

  logic [NM-1:0] req;
  logic [NM-1:0] others;
  logic [2:0]    pk_idle;
  logic [2:0]    pk_hand;
  logic          rel;

  // {found, index} of first set bit scanning start, start+1, ... mod NM
  function automatic logic [2:0] pick(
    input logic [NM-1:0] r,
    input logic [1:0]    start
  );
    logic [2:0] res;
    int idx;
    res = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NM;
      if (r[idx]) res = {1'b1, 2'(idx)};
    end
    return res;
  endfunction

  function automatic logic [1:0] inc(input logic [1:0] v);
    return (int'(v) + 1 == NM) ? 2'd0 : v + 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt_r   <= '1;
      owner_r <= '0;
      busy_r  <= 1'b0;
      ptr_r   <= '0;
      hcnt_r  <= '0;
    end else begin
      state   <= state_nx;
      gnt_r   <= gnt_nx;
      owner_r <= owner_nx;
      busy_r  <= busy_nx;
      ptr_r   <= ptr_nx;
      hcnt_r  <= hcnt_nx;
    end
  end

  always_comb begin
    req      = ~bus.breq_;
    others   = req & ~(ONE << owner_r);
    pk_idle  = pick(req, ptr_r);
    // handoff scan starts after the owner and never lands on it
    pk_hand  = pick(others, inc(owner_r));
    state_nx = state;
    gnt_nx   = gnt_r;
    owner_nx = owner_r;
    busy_nx  = busy_r;
    ptr_nx   = ptr_r;
    hcnt_nx  = hcnt_r;
    rel      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pk_idle[2]) begin
          state_nx = GRANT;
          gnt_nx   = ~(ONE << pk_idle[1:0]);
          owner_nx = pk_idle[1:0];
          busy_nx  = 1'b1;
          hcnt_nx  = '0;
        end
      end
      GRANT: begin
        rel = !req[owner_r] ||
              ((hcnt_r == HLAST) && (|others));
        if (rel) begin
          ptr_nx  = inc(owner_r);
          hcnt_nx = '0;
          if (pk_hand[2]) begin
            gnt_nx   = ~(ONE << pk_hand[1:0]);
            owner_nx = pk_hand[1:0];
          end else begin
            state_nx = IDLE;
            gnt_nx   = '1;
            busy_nx  = 1'b0;
          end
        end else if (hcnt_r != HMAX) begin
          hcnt_nx = hcnt_r + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic                      rd_mux;
  logic                      wr_mux;
  logic [BUS_ADDR_WIDTH-1:0] adr_mux;
  logic [DATA_WIDTH-1:0]     wd_mux;

  always_comb begin
    rd_mux  = 1'b0;
    wr_mux  = 1'b0;
    adr_mux = '0;
    wd_mux  = '0;
    if (state == GRANT) begin
      rd_mux  = bus.m_memread[owner_r];
      wr_mux  = bus.m_memwrite[owner_r];
      adr_mux = bus.m_adr[int'(owner_r)*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
      wd_mux  = bus.m_wdata[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.gnt_      = gnt_r;
  assign bus.owner     = owner_r;
  assign bus.busy      = busy_r;
  assign bus.memread   = rd_mux;
  assign bus.memwrite  = wr_mux;
  assign bus.adr       = adr_mux;
  assign bus.writedata = wd_mux;

`ifdef BUS_ARB_STAT_EN
  logic [15:0] stall_q;

  // a cycle stalls when some requester is not the grant holder
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stat_clr) begin
      stall_q <= '0;
    end else if ((|(req & gnt_r)) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter and bus multiplexer that shares one memory port between up to four mips32-class masters.
- Each master signals demand with an active-low request (breq_-style) and receives an active-low grant.
- The granted master's memread/memwrite/adr/writedata are steered onto the shared memory bus.
- A hold limit keeps one master from monopolising the bus while others wait.

Parameters:
- NUM_MASTERS, 4, number of requesters; legal values 2..4. Unused request inputs are tied high.
- MAX_HOLD, 8, maximum consecutive granted cycles while another master is requesting; legal values 1..255.
- BUS_ADDR_WIDTH, 10, shared bus address width.
- DATA_WIDTH, 32, shared bus data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- breq_  in  NUM_MASTERS  per-master request, active-low; bit i belongs to master i
- m_memread  in  NUM_MASTERS  per-master read strobe
- m_memwrite  in  NUM_MASTERS  per-master write strobe
- m_adr  in  NUM_MASTERS*BUS_ADDR_WIDTH  flattened addresses; master i occupies bits [i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH]
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  flattened write data; same packing as m_adr
- gnt_  out  NUM_MASTERS  per-master grant, active-low; at most one bit low
- owner  out  2  index of the current grant holder; valid only when busy=1
- busy  out  1  1 while any grant is held
- memread  out  1  shared bus read strobe
- memwrite  out  1  shared bus write strobe
- adr  out  BUS_ADDR_WIDTH  shared bus address
- writedata  out  DATA_WIDTH  shared bus write data

Behaviour:
- Reset (sampled on a rising edge of clk while reset=1):
  - state=IDLE, gnt_ all ones, owner=0, busy=0
  - round-robin pointer ptr=0, hold counter hcnt=0
  - memread=0, memwrite=0, adr=0, writedata=0
- States are IDLE and GRANT. gnt_, owner, busy, ptr and hcnt are registered.
- IDLE:
  - If any breq_ bit is low, choose the first requester scanning ptr, ptr+1, ... modulo NUM_MASTERS.
  - At the next edge: assert that gnt_ bit, load owner, set busy=1, set hcnt=0, go to GRANT.
  - Arbitration latency from request to grant is exactly 1 cycle.
- GRANT:
  - Shared bus outputs are combinational copies of the owner's m_memread/m_memwrite/m_adr/m_wdata.
  - Strobes from non-owners are ignored and never reach the bus.
  - Each cycle, hcnt increments, saturating at MAX_HOLD.
- Release (evaluated each GRANT cycle). The grant ends at the next edge if either:
  - (a) breq_[owner]=1, or
  - (b) hcnt==MAX_HOLD-1 and some other master is requesting.
- On release:
  - ptr <= owner+1 (mod NUM_MASTERS).
  - If another master is requesting, the next owner is chosen by scanning from owner+1, skipping the current owner. The handoff is zero-bubble: the new gnt_ goes low at the same edge the old one goes high; hcnt=0.
  - If no other master is requesting, return to IDLE with gnt_ all ones and busy=0.
- A master preempted by (b) keeps breq_ low and re-arbitrates normally. With 2+ requesters, it is served again within NUM_MASTERS-1 grants.
- If the owner continues requesting and nobody else requests, the grant is held indefinitely (hcnt saturates, no release).
- Outside GRANT: memread=0, memwrite=0, adr=0, writedata=0.
- A request that rises during the release cycle does not cancel the handoff already computed.
- Reset asserted mid-GRANT: the next edge forces the reset values; any bus cycle in progress is dropped. Masters must re-request.
- owner is meaningful only when busy=1; the bench must not check it otherwise.

Optional Feature:
- Macro: BUS_ARB_STAT_EN.
- When defined, adds output port stall_cnt [15:0]:
  - Counts cycles in which at least one breq_ bit is low whose gnt_ bit is high.
  - Saturates at 16'hFFFF and resets to 0.
  - Adds input stat_clr; stat_clr=1 zeroes the count at the next edge and takes priority over increment.
- When undefined, neither port nor counter exists, and the core behaviour is identical.

Test Plan:
1. After reset, master 2 drops breq_ at cycle 0 → gnt_=4'b1011 at cycle 1; owner=2. With m_memread[2]=1 and adr=10'h040: memread=1, adr=10'h040.
2. Masters 0 and 1 hold breq_ low continuously with MAX_HOLD=8:
   - Master 0 is granted for exactly 8 cycles.
   - Then the grant passes to master 1 with no bubble cycle, then back to master 0, and so on.
3. Master 3 requests alone for 20 cycles → gnt_[3] stays low all 20 cycles (no preemption). Release → gnt_=4'b1111 and busy=0 one edge later.
4. Master 1 is the owner and masters 0 and 3 are waiting; master 1 releases → next grant goes to master 3 (scan from 2), then master 0.
5. Non-owner master 0 drives m_memwrite=1, m_wdata=32'hDEADBEEF while master 2 owns and writes 32'h12345678 → memwrite reflects master 2 only; writedata=32'h12345678.
6. Reset asserted during GRANT with busy=1 → next edge: gnt_=4'b1111, busy=0, memwrite=0. With BUS_ARB_STAT_EN: 5 cycles of one waiting master → stall_cnt=5; stat_clr → 0.
